wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have no parameters; all widths fixed (XLEN = 32).
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_reset_n  in  1  asynchronous, active-low reset.
REQ-004 i_valid  in  1  MEM slot holds a real instruction.
REQ-005 i_pc  in  32  PC of MEM-slot instruction.
REQ-006 i_alu_data  in  32  ALU result / effective address from EX/MEM register.
REQ-007 i_lsu_data  in  32  load data from MEM stage, already extended, valid same cycle.
REQ-008 i_rd_addr  in  5  destination register index.
REQ-009 i_rd_wren  in  1  instruction writes rd.
REQ-010 i_wb_sel  in  2  writeback source select (see REQ-016).
REQ-011 i_stall  in  1  hold WB register contents.
REQ-012 i_flush  in  1  load a bubble into the WB register.
REQ-013 o_rd_addr / o_rd_data / o_rd_wren  out  5/32/1  regfile write port and forwarding source.
REQ-014 o_insn_vld / o_pc_debug  out  1/32  retired-instruction strobe and its PC.
REQ-015 o_cycle_cnt / o_instret_cnt  out  64/64  free-running cycle and retired-instruction counters.

Function
REQ-016 Select, combinationally in the MEM cycle: 00 ALU = i_alu_data; 01 LOAD = i_lsu_data; 10 LINK = i_pc + 4 (mod 2^32); 11 INSTRET = o_instret_cnt[31:0] at that cycle.
REQ-017 One-cycle latency: selected data, rd, wren, valid and PC registered on the edge following the MEM cycle.
REQ-018 Capture condition: !i_stall && !i_flush; entry loads i_valid, i_rd_addr, i_pc and selected data.
REQ-019 i_flush = 1: register loads bubble (valid 0, wren 0, rd 0, data 0, pc 0); flush overrides stall.
REQ-020 i_stall = 1 && !i_flush: all WB register fields hold; no counter other than cycle changes.
REQ-021 o_rd_wren = registered (i_rd_wren && i_valid && i_rd_addr != 0); writes to x0 are never asserted.
REQ-022 o_insn_vld = registered valid; while stalled it stays at the held value, but the held instruction counts once.
REQ-023 o_instret_cnt increments by 1 on each edge where the capture condition holds with i_valid = 1; it wraps 2^64-1 -> 0.
REQ-024 o_cycle_cnt increments by 1 every edge after reset release, including stall/flush cycles; wraps 2^64-1 -> 0.
REQ-025 INSTRET select reads the pre-increment counter value; a retire in the same cycle is not included.
REQ-026 Data fields are don't-care when i_valid = 0 but SHALL still be captured (no X propagation: inputs X -> outputs X only if valid).

Reset
REQ-027 While i_reset_n = 0: o_rd_addr 0, o_rd_data 0, o_rd_wren 0, o_insn_vld 0, o_pc_debug 0, both counters 0, asynchronously.
REQ-028 First edge with i_reset_n = 1 performs normal capture and cycle_cnt -> 1.
REQ-029 Reset asserted mid-stall or mid-flush discards the held entry; no partial update survives.

Structure
REQ-030 Shared package pipeline_pkg holds XLEN and enum wb_sel_e {WB_ALU, WB_LOAD, WB_LINK, WB_INSTRET}; the EX/MEM register uses the same type.
REQ-031 Sub-module wb_counters holds both 64-bit counters (inputs: i_clk, i_reset_n, retire strobe); wb_stage holds mux and WB register.

Verification
REQ-032 ALU write: valid, sel 00, alu 0x0000_1234, rd 5, wren -> next cycle rd_addr 5, rd_data 0x1234, rd_wren 1, insn_vld 1, instret 1.
REQ-033 Load and link: sel 01 lsu 0xFFFF_FF80 rd 7 -> data 0xFFFF_FF80; sel 10 pc 0xFFFF_FFFC -> data 0x0000_0000.
REQ-034 x0 and bubble: rd 0 with wren 1 -> rd_wren 0, instret still +1; valid 0 -> insn_vld 0, instret unchanged.
REQ-035 Stall 3 cycles then release with one valid insn held -> outputs stable 3 cycles, instret +1 total, cycle_cnt +3; stall+flush same cycle -> bubble.
REQ-036 Counter wrap: force instret 0xFFFF_FFFF_FFFF_FFFF, retire one -> 0; sel 11 same cycle returns 0xFFFF_FFFF.
REQ-037 Reset asserted asynchronously between edges during stall -> all outputs 0 immediately; after release cycle_cnt counts 1, 2, 3.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions.
//   XLEN      : datapath width (32).
//   wb_sel_e  : writeback source select, shared by the EX/MEM register and WB stage.
package pipeline_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        WB_ALU     = 2'b00,
        WB_LOAD    = 2'b01,
        WB_LINK    = 2'b10,
        WB_INSTRET = 2'b11
    } wb_sel_e;

endpackage : pipeline_pkg

// File: rtl/wb_counters.sv
// Free-running 64-bit performance counters for the writeback stage.
// Ports:
//   i_clk          : clock, rising edge
//   i_reset_n      : asynchronous active-low reset, clears both counters
//   i_retire       : one instruction retires on this edge
//   o_cycle_cnt    : cycles since reset release (wraps)
//   o_instret_cnt  : retired instructions (wraps)
module wb_counters (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_retire,
    output logic [63:0] o_cycle_cnt,
    output logic [63:0] o_instret_cnt
);

    logic [63:0] cycle_q;
    logic [63:0] instret_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (i_retire) begin
                instret_q <= instret_q + 64'd1;
            end
        end
    end

    assign o_cycle_cnt   = cycle_q;
    assign o_instret_cnt = instret_q;

endmodule : wb_counters

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value in the MEM cycle and registers it
// into the WB register that drives the register-file write port.
// Ports:
//   i_clk, i_reset_n              : clock / asynchronous active-low reset
//   i_valid, i_pc                 : MEM-slot instruction valid and PC
//   i_alu_data, i_lsu_data        : ALU result and extended load data
//   i_rd_addr, i_rd_wren          : destination register and write request
//   i_wb_sel                      : writeback source (wb_sel_e encoding)
//   i_stall, i_flush              : hold WB register / load bubble (flush wins)
//   o_rd_addr/o_rd_data/o_rd_wren : regfile write port and forwarding source
//   o_insn_vld, o_pc_debug        : retired-instruction strobe and PC
//   o_cycle_cnt, o_instret_cnt    : 64-bit performance counters
module wb_stage
    import pipeline_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic [XLEN-1:0] i_lsu_data,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_rd_wren,
    input  logic [1:0]      i_wb_sel,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic [4:0]      o_rd_addr,
    output logic [XLEN-1:0] o_rd_data,
    output logic            o_rd_wren,
    output logic            o_insn_vld,
    output logic [XLEN-1:0] o_pc_debug,
    output logic [63:0]     o_cycle_cnt,
    output logic [63:0]     o_instret_cnt
);

    logic            capture;
    logic            retire;
    logic [XLEN-1:0] sel_data;

    assign capture = !i_stall && !i_flush;
    assign retire  = capture && i_valid;

    // INSTRET reads the counter before this cycle's retire is applied.
    always_comb begin
        sel_data = i_alu_data;
        case (wb_sel_e'(i_wb_sel))
            WB_ALU:     sel_data = i_alu_data;
            WB_LOAD:    sel_data = i_lsu_data;
            WB_LINK:    sel_data = i_pc + 32'd4;
            WB_INSTRET: sel_data = o_instret_cnt[XLEN-1:0];
            default:    sel_data = i_alu_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
            o_rd_wren  <= 1'b0;
            o_insn_vld <= 1'b0;
            o_pc_debug <= '0;
        end else if (i_flush) begin
            o_rd_addr  <= '0;
            o_rd_data  <= '0;
            o_rd_wren  <= 1'b0;
            o_insn_vld <= 1'b0;
            o_pc_debug <= '0;
        end else if (!i_stall) begin
            o_rd_addr  <= i_rd_addr;
            o_rd_data  <= sel_data;
            o_rd_wren  <= i_rd_wren && i_valid && (i_rd_addr != 5'd0);
            o_insn_vld <= i_valid;
            o_pc_debug <= i_pc;
        end
    end

    wb_counters u_counters (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_retire      (retire),
        .o_cycle_cnt   (o_cycle_cnt),
        .o_instret_cnt (o_instret_cnt)
    );

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases followed by randomized
// traffic, checked against a cycle-level behavioural model.
module tb_wb_stage;

    logic        i_clk;
    logic        i_reset_n;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_alu_data;
    logic [31:0] i_lsu_data;
    logic [4:0]  i_rd_addr;
    logic        i_rd_wren;
    logic [1:0]  i_wb_sel;
    logic        i_stall;
    logic        i_flush;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_rd_wren;
    logic        o_insn_vld;
    logic [31:0] o_pc_debug;
    logic [63:0] o_cycle_cnt;
    logic [63:0] o_instret_cnt;

    wb_stage dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_valid       (i_valid),
        .i_pc          (i_pc),
        .i_alu_data    (i_alu_data),
        .i_lsu_data    (i_lsu_data),
        .i_rd_addr     (i_rd_addr),
        .i_rd_wren     (i_rd_wren),
        .i_wb_sel      (i_wb_sel),
        .i_stall       (i_stall),
        .i_flush       (i_flush),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_rd_wren     (o_rd_wren),
        .o_insn_vld    (o_insn_vld),
        .o_pc_debug    (o_pc_debug),
        .o_cycle_cnt   (o_cycle_cnt),
        .o_instret_cnt (o_instret_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference model state: what the WB register and counters should hold.
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_wren;
    logic        m_vld;
    logic [31:0] m_pc;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".rd_addr"},  {59'd0, o_rd_addr},  {59'd0, m_rd});
        check({tag, ".rd_data"},  {32'd0, o_rd_data},  {32'd0, m_data});
        check({tag, ".rd_wren"},  {63'd0, o_rd_wren},  {63'd0, m_wren});
        check({tag, ".insn_vld"}, {63'd0, o_insn_vld}, {63'd0, m_vld});
        check({tag, ".pc_debug"}, {32'd0, o_pc_debug}, {32'd0, m_pc});
        check({tag, ".cycle"},    o_cycle_cnt,         m_cycle);
        check({tag, ".instret"},  o_instret_cnt,       m_instret);
    endtask

    task automatic model_reset();
        m_rd = '0; m_data = '0; m_wren = 1'b0; m_vld = 1'b0; m_pc = '0;
        m_cycle = '0; m_instret = '0;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [31:0] pc,
                         input logic [31:0] alu, input logic [31:0] lsu,
                         input logic [4:0] rd, input logic wren,
                         input logic stall, input logic flush);
        i_valid = v; i_wb_sel = sel; i_pc = pc; i_alu_data = alu; i_lsu_data = lsu;
        i_rd_addr = rd; i_rd_wren = wren; i_stall = stall; i_flush = flush;
    endtask

    // Advance one clock: predict from the current inputs, then compare #1 after the edge.
    task automatic cycle(input string tag);
        logic [31:0] value;
        case (i_wb_sel)
            2'd0:    value = i_alu_data;
            2'd1:    value = i_lsu_data;
            2'd2:    value = i_pc + 32'd4;
            default: value = m_instret[31:0];
        endcase
        @(posedge i_clk);
        #1;
        m_cycle = m_cycle + 64'd1;
        if (i_flush) begin
            m_rd = '0; m_data = '0; m_wren = 1'b0; m_vld = 1'b0; m_pc = '0;
        end else if (!i_stall) begin
            m_rd   = i_rd_addr;
            m_data = value;
            m_wren = i_rd_wren && i_valid && (i_rd_addr != 5'd0);
            m_vld  = i_valid;
            m_pc   = i_pc;
            if (i_valid) m_instret = m_instret + 64'd1;
        end
        check_all(tag);
    endtask

    initial begin
        i_reset_n = 1'b0;
        drive(1'b0, 2'd0, '0, '0, '0, 5'd0, 1'b0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all("reset");
        i_reset_n = 1'b1;

        // ALU write
        drive(1'b1, 2'd0, 32'h0000_0100, 32'h0000_1234, 32'hDEAD_BEEF, 5'd5, 1'b1, 1'b0, 1'b0);
        cycle("alu");
        check("alu.instret_is_1", o_instret_cnt, 64'd1);

        // Load and link (link wraps to zero)
        drive(1'b1, 2'd1, 32'h0000_0104, 32'h1111_1111, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0);
        cycle("load");
        drive(1'b1, 2'd2, 32'hFFFF_FFFC, 32'h2222_2222, 32'h3333_3333, 5'd1, 1'b1, 1'b0, 1'b0);
        cycle("link");
        check("link.wraps", {32'd0, o_rd_data}, 64'd0);

        // x0 write suppressed but still retires; bubble does not retire
        drive(1'b1, 2'd0, 32'h0000_0200, 32'h0000_00AA, '0, 5'd0, 1'b1, 1'b0, 1'b0);
        cycle("x0");
        drive(1'b0, 2'd0, 32'h0000_0204, 32'h0000_00BB, '0, 5'd9, 1'b1, 1'b0, 1'b0);
        cycle("bubble");

        // Capture one instruction, stall 3 cycles with changing inputs, release
        drive(1'b1, 2'd3, 32'h0000_0300, 32'h0, '0, 5'd12, 1'b1, 1'b0, 1'b0);
        cycle("pre_stall");
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 2'd0, 32'h0000_0400 + i, 32'hC0DE_0000 + i, '0, 5'd13, 1'b1, 1'b1, 1'b0);
            cycle("stall");
            check("stall.held_pc", {32'd0, o_pc_debug}, 64'h300);
        end
        drive(1'b1, 2'd0, 32'h0000_0500, 32'h0000_5555, '0, 5'd14, 1'b1, 1'b0, 1'b0);
        cycle("stall_release");

        // Stall and flush together: flush wins
        drive(1'b1, 2'd0, 32'h0000_0600, 32'h0000_6666, '0, 5'd15, 1'b1, 1'b1, 1'b1);
        cycle("stall_flush");
        check("stall_flush.vld", {63'd0, o_insn_vld}, 64'd0);

        // Instret wrap, with INSTRET select reading the pre-increment value
        dut.u_counters.instret_q = '1;
        m_instret = '1;
        drive(1'b1, 2'd3, 32'h0000_0700, '0, '0, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle("wrap");
        check("wrap.data", {32'd0, o_rd_data}, 64'hFFFF_FFFF);
        check("wrap.instret", o_instret_cnt, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [4:0] rd;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            drive($urandom_range(0, 3) != 0, 2'($urandom), $urandom, $urandom, $urandom,
                  rd, 1'($urandom), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
            cycle("rand");
        end

        // Asynchronous reset between edges while stalled
        drive(1'b1, 2'd0, 32'h0000_0800, 32'h0000_8888, '0, 5'd8, 1'b1, 1'b0, 1'b0);
        cycle("pre_areset");
        i_stall = 1'b1;
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all("areset");
        #2;
        i_reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle("post_reset");
            check("post_reset.cycle", o_cycle_cnt, 64'(i));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_wb_stage
